// File: rtl/seg7_scan_n_if.sv
// seg7_scan_n_if: load-side and display-side signals of the seven-segment scanner
interface seg7_scan_n_if #(
   parameter int NUM_DIGITS = 4
);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   logic [4*NUM_DIGITS-1:0] data;
   logic [NUM_DIGITS-1:0]   dp;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    load;
   logic                    pending;
   logic [7:0]              seg;
   logic [NUM_DIGITS-1:0]   anode;
   logic [IW-1:0]           digit_idx;
   logic                    frame_done;
   modport master (output data, dp, blank, load, input pending, seg, anode, digit_idx, frame_done);
   modport slave  (input data, dp, blank, load, output pending, seg, anode, digit_idx, frame_done);
endinterface

// File: rtl/seg7_scan_n.sv
// seg7_scan_n: double-buffered multiplexed common-anode 7-seg driver; SEG7_LZ_BLANK_EN adds leading-zero suppression
module seg7_scan_n #(
   parameter int NUM_DIGITS = 4,
   parameter int DIV_BITS   = 16
) (
   input logic         clk,
   input logic         rst,
   seg7_scan_n_if.slave bus
);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

   logic [DIV_BITS-1:0]     r_pre;
   logic [IW-1:0]           r_idx;
   logic [4*NUM_DIGITS-1:0] r_act_data, r_pend_data;
   logic [NUM_DIGITS-1:0]   r_act_dp, r_pend_dp, r_act_bl, r_pend_bl;
   logic                    r_pending, r_frame_done;
   logic [7:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_anode;
   logic [IW-1:0]           r_digit_idx;
   logic                    w_tick, w_boundary, w_dp, w_blank, w_lz;
   logic [3:0]              w_nib;
   logic [6:0]              w_segs;

   assign w_tick     = &r_pre;
   assign w_boundary = w_tick && (r_idx == LAST);
   assign w_nib      = r_act_data[4*r_idx +: 4];
   assign w_dp       = r_act_dp[r_idx];
   assign w_blank    = r_act_bl[r_idx];

   // prescaler and digit index; index wraps explicitly so non-power-of-2 counts work
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre <= '0;
         r_idx <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
         if (w_tick) r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
      end
   end

   // load captures into pending; pending moves to active only on a frame boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_data  <= '0;
         r_pend_dp    <= '0;
         r_pend_bl    <= '0;
         r_act_data   <= '0;
         r_act_dp     <= '0;
         r_act_bl     <= '0;
         r_pending    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_boundary;
         if (w_boundary && r_pending) begin
            r_act_data <= r_pend_data;
            r_act_dp   <= r_pend_dp;
            r_act_bl   <= r_pend_bl;
         end
         if (bus.load) begin
            r_pend_data <= bus.data;
            r_pend_dp   <= bus.dp;
            r_pend_bl   <= bus.blank;
            r_pending   <= 1'b1;
         end else if (w_boundary) begin
            r_pending <= 1'b0;
         end
      end
   end

   // hex to abcdefg, active low
   always_comb begin
      w_segs = 7'b1111111;
      case (w_nib)
         4'h0: w_segs = 7'b0000001;
         4'h1: w_segs = 7'b1001111;
         4'h2: w_segs = 7'b0010010;
         4'h3: w_segs = 7'b0000110;
         4'h4: w_segs = 7'b1001100;
         4'h5: w_segs = 7'b0100100;
         4'h6: w_segs = 7'b0100000;
         4'h7: w_segs = 7'b0001111;
         4'h8: w_segs = 7'b0000000;
         4'h9: w_segs = 7'b0000100;
         4'hA: w_segs = 7'b0001000;
         4'hB: w_segs = 7'b1100000;
         4'hC: w_segs = 7'b0110001;
         4'hD: w_segs = 7'b1000010;
         4'hE: w_segs = 7'b0110000;
         default: w_segs = 7'b0111000;
      endcase
   end

`ifdef SEG7_LZ_BLANK_EN
   logic w_hi_zero;
   // selected digit is a leading zero when it and every higher nibble are zero, dp off, not digit 0
   always_comb begin
      w_hi_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (i >= int'(r_idx) && r_act_data[4*i +: 4] != 4'd0) w_hi_zero = 1'b0;
      w_lz = w_hi_zero && !w_dp && (r_idx != '0);
   end
`else
   assign w_lz = 1'b0;
`endif

   // registered pin drive: reflects index and active buffer of the previous cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg       <= 8'hFF;
         r_anode     <= '1;
         r_digit_idx <= '0;
      end else begin
         r_seg       <= (w_blank || w_lz) ? 8'hFF : {w_segs, ~w_dp};
         r_anode     <= ~(NUM_DIGITS'(1) << r_idx);
         r_digit_idx <= r_idx;
      end
   end

   assign bus.pending    = r_pending;
   assign bus.frame_done = r_frame_done;
   assign bus.seg        = r_seg;
   assign bus.anode      = r_anode;
   assign bus.digit_idx  = r_digit_idx;
endmodule

// File: doc/seg7_scan_n.md
Name: seg7_scan_n

Overview:
- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
- Input: hex nibble per digit plus per-digit decimal point and blank controls.
- Double-buffered load handshake: new values take effect only at frame boundaries, so a displayed frame never mixes old and new digits.
- Sits between datapath/debug registers and board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned, legal range 2..8.
- DIV_BITS, 16: prescaler width; each digit is shown for 2^DIV_BITS clk cycles; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- data  input  4*NUM_DIGITS  hex value; data[4i+3:4i] is digit i, digit 0 least significant
- dp  input  NUM_DIGITS  decimal point enable per digit, 1=lit
- blank  input  NUM_DIGITS  per-digit blank, 1=all segments off
- load  input  1  single-cycle strobe; captures data/dp/blank into pending buffer
- pending  output  1  1 while a captured value awaits the next frame boundary
- seg  output  8  active-low; seg[7:1]=a..g, seg[0]=dp
- anode  output  NUM_DIGITS  active-low digit enables; anode[i] low selects digit i
- digit_idx  output  clog2(NUM_DIGITS)  index of digit currently driven on anode/seg
- frame_done  output  1  one-cycle pulse when the last digit's dwell ends

Behaviour:
- Reset (rst=1 at a clk edge), all registers cleared:
  - prescaler=0, internal index=0, active and pending buffers=0, pending=0, frame_done=0.
  - seg=8'hFF and anode=all ones (display dark).
- Prescaler: counts 0..2^DIV_BITS-1 and wraps. tick=1 when it equals all ones.
- Index: on tick, advances by 1; wraps from NUM_DIGITS-1 to 0 (also for non-power-of-2 NUM_DIGITS).
- Frame boundary: a tick while index==NUM_DIGITS-1. At the boundary, frame_done=1 for exactly the following cycle.
- Outputs registered, one-cycle latency: seg, anode and digit_idx at cycle t+1 reflect the index and active buffer at cycle t.
  - First cycle after reset release: anode[0]=0, others 1, seg=8'h03 (digit "0", dp off).
- Exactly one anode bit is low at any time outside reset.
- Segment encoding, seg[7:1] abcdefg, 0=on:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000, C:0110001, d:1000010, E:0110000, F:0111000
- seg[0] = ~dp of the selected digit.
- blank of the selected digit forces seg=8'hFF, dp included. The anode is still driven, so scan timing is unchanged.
- Load handshake:
  - load=1 copies data/dp/blank into pending buffer and sets pending=1 next cycle.
  - A repeated load before the boundary overwrites the pending buffer (last write wins).
- At a frame boundary with pending=1: pending buffer copies to active buffer; pending clears.
- Load coinciding with the boundary:
  - Active takes the previous pending contents (if pending=1).
  - The new load is captured into the pending buffer.
  - pending is 1 on the next cycle.
- At a boundary with pending=0: active buffer is unchanged.
- Reset mid-frame or mid-load: discards pending and active contents; display dark for the reset cycle(s); scan restarts at digit 0.
- Inputs are sampled only on load; changes without load have no effect.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- When defined: leading-zero suppression on the active buffer.
  - Blanks digit i (seg=8'hFF) if its nibble and all higher-digit nibbles are 0 and its dp bit is 0.
  - Digit 0 is never suppressed.
  - An explicit blank bit still blanks regardless.
- When not defined: zeros are always displayed; no extra logic is synthesised.

Test Plan:
- NUM_DIGITS=4, DIV_BITS=2; reset, release -> seg=8'hFF during reset. Then anode cycles 1110,1101,1011,0111, 4 clks each. frame_done pulses every 16 clks; seg=8'h03 on every digit.
- load data=16'h4A1F, dp=4'b0010, blank=0, mid-frame -> pending=1 until the boundary; digits unchanged until then. Next frame shows digit0 seg=8'h71, digit1 seg=8'h9E, digit2 seg=8'h11, digit3 seg=8'h99; pending=0.
- Two loads, 16'h1111 then 16'h2222, before one boundary -> next frame shows all digits 8'h25. Load at the boundary cycle with 16'h3333 -> 2222 frame appears, pending=1, 3333 appears one frame later.
- blank=4'b1000 with data=16'h8888 -> digit3 seg=8'hFF with anode[3]=0 in its slot; digits 0-2 show 8'h01.
- Assert rst for 1 cycle while digit 2 is active and pending=1 -> next cycle seg=8'hFF, anode=4'b1111, pending=0. Then scan restarts at digit 0 showing 8'h03.
- With SEG7_LZ_BLANK_EN, load 16'h0050 -> digits 3,2 seg=8'hFF, digit1 8'h49, digit0 8'h03. Load 16'h0000 -> only digit0 shows 8'h03.
